// File: rtl/aes_pkg.sv
// Shared types, round constants and word helpers for the AES-128 key schedule.
package aes_pkg;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_block_t;

    localparam int AES128_NR = 10;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        BACK
    } ks_state_t;

    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // Rounds outside 1..10 yield zero; only BACK consumes this, where round >= 1.
    function automatic aes_word_t rcon_word(input logic [3:0] r);
        aes_word_t rc;
        rc = '0;
        for (int i = 1; i <= 10; i++) begin
            if (r == 4'(i)) rc = {RCON[i], 24'h0};
        end
        return rc;
    endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Combinational forward AES S-box on all four bytes of a word.
module aes_sbox_word
    import aes_pkg::*;
(
    input  aes_word_t din,
    output aes_word_t dout
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0.
    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = gf_mul(x, x);
        inv = sq;
        for (int k = 2; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_byte
        assign dout[8*g +: 8] = sbox_byte(din[8*g +: 8]);
    end

endmodule

// File: rtl/aes_inv_key_sched.sv
// Reverse AES-128 key schedule: streams round keys 10..0, one 32-bit word per handshake,
// regenerating each earlier round key in place over four BACK cycles.
module aes_inv_key_sched
    import aes_pkg::*;
#(
    parameter int NR = AES128_NR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  aes_block_t key_in,
    input  logic       key_valid,
    output logic       key_ready,
    output aes_word_t  rk_word,
    output logic       rk_valid,
    input  logic       rk_ready,
    output logic [3:0] rk_round,
    output logic [1:0] rk_idx,
    output logic       rk_last
);

    ks_state_t         state, state_nxt;
    aes_word_t [3:0]   w;
    logic [3:0]        round;
    logic [1:0]        idx;
    logic [1:0]        step;
    aes_word_t         sbox_in;
    aes_word_t         sbox_out;

    assign sbox_in = rot_word(w[3]);

    aes_sbox_word u_sbox (
        .din  (sbox_in),
        .dout (sbox_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            w     <= '0;
            round <= '0;
            idx   <= '0;
            step  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        w[0]  <= key_in[127:96];
                        w[1]  <= key_in[95:64];
                        w[2]  <= key_in[63:32];
                        w[3]  <= key_in[31:0];
                        round <= 4'(NR);
                        idx   <= '0;
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        idx  <= idx + 2'd1;
                        step <= '0;
                    end
                end
                BACK: begin
                    step <= step + 2'd1;
                    // w[3] is rewritten first so step 3 sees the previous round's last word.
                    case (step)
                        2'd0: w[3] <= w[3] ^ w[2];
                        2'd1: w[2] <= w[2] ^ w[1];
                        2'd2: w[1] <= w[1] ^ w[0];
                        default: begin
                            w[0]  <= w[0] ^ sbox_out ^ rcon_word(round);
                            round <= round - 4'd1;
                            idx   <= '0;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        key_ready = 1'b0;
        rk_valid  = 1'b0;
        rk_word   = '0;
        rk_last   = 1'b0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) state_nxt = EMIT;
            end
            EMIT: begin
                rk_valid = 1'b1;
                rk_word  = w[idx];
                rk_last  = (round == 4'd0) && (idx == 2'd3);
                if (rk_ready && idx == 2'd3) state_nxt = (round == 4'd0) ? IDLE : BACK;
            end
            BACK: begin
                if (step == 2'd3) state_nxt = EMIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rk_round = round;
    assign rk_idx   = idx;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Randomized bench for aes_inv_key_sched against a table-driven reverse key-expansion model.
module tb_aes_inv_key_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [31:0]  rk_word;
    logic         rk_valid;
    logic         rk_ready = 1'b0;
    logic [3:0]   rk_round;
    logic [1:0]   rk_idx;
    logic         rk_last;

    int           errors = 0;
    int           checks = 0;
    logic [7:0]   sb [256];
    logic [7:0]   rc [1:10];
    logic [31:0]  exp_w [44];
    logic [31:0]  fips_w [44];
    bit           use_fips = 0;

    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

    always #5 clk = ~clk;

    aes_inv_key_sched #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk_word   (rk_word),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_round  (rk_round),
        .rk_idx    (rk_idx),
        .rk_last   (rk_last)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Polynomial product then reduction by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = '0;
        for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
        return prod[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (tb_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[x] = s;
        end
        rc[1] = 8'h01;
        for (int k = 2; k <= 10; k++) rc[k] = tb_gmul(rc[k-1], 8'h02);
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] v);
        return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
    endfunction

    // Invert w[i] = w[i-4] ^ f(w[i-1]) starting from the round-10 key.
    task automatic build_ref(input logic [127:0] k10);
        logic [31:0] ws [44];
        logic [31:0] t;
        ws[40] = k10[127:96]; ws[41] = k10[95:64]; ws[42] = k10[63:32]; ws[43] = k10[31:0];
        for (int i = 43; i >= 4; i--) begin
            t = ws[i-1];
            if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rc[i/4], 24'h0};
            ws[i-4] = ws[i] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            for (int j = 0; j < 4; j++) exp_w[4*(10-r)+j] = ws[4*r+j];
    endtask

    // Caller must be at a negedge. mode: 0 ready high, 1 random ready,
    // 2 seven-cycle stall mid-round, 3 key_valid held high with alt_key.
    task automatic run_stream(input logic [127:0] key, input int mode, input logic [127:0] alt_key);
        int          n = 0;
        int          cyc = 0;
        int          stall = 0;
        bit          done = 0;
        bit          held = 0;
        logic [31:0] pw = '0;
        logic [3:0]  pr = '0;
        logic [1:0]  pi = '0;
        build_ref(key);
        chk("key_ready_before_load", 32'(key_ready), 32'd1);
        key_in    = key;
        key_valid = 1'b1;
        rk_ready  = 1'b1;
        @(posedge clk);
        cyc = 1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            if (mode == 3) key_in = alt_key;
            else key_valid = 1'b0;
            if (key_ready) begin
                done      = 1;
                key_valid = 1'b0;
            end else begin
                if (mode == 1) rk_ready = 1'($urandom_range(0, 1));
                else if (mode == 2 && n == 22 && stall < 7) begin
                    rk_ready = 1'b0;
                    stall++;
                end else rk_ready = 1'b1;
                if (held) begin
                    chk("stall_word", rk_word, pw);
                    chk("stall_round", 32'(rk_round), 32'(pr));
                    chk("stall_idx", 32'(rk_idx), 32'(pi));
                end
                if (rk_valid && rk_ready) begin
                    if (n < 44) begin
                        chk($sformatf("word%0d", n), rk_word, exp_w[n]);
                        chk($sformatf("round%0d", n), 32'(rk_round), 32'(10 - n / 4));
                        chk($sformatf("idx%0d", n), 32'(rk_idx), 32'(n % 4));
                        chk($sformatf("last%0d", n), 32'(rk_last), 32'(n == 43));
                        if (use_fips && (n < 8 || n >= 40))
                            chk($sformatf("fips_word%0d", n), rk_word, fips_w[n]);
                    end
                    n++;
                end
                held = rk_valid && !rk_ready;
                pw = rk_word;
                pr = rk_round;
                pi = rk_idx;
                @(posedge clk);
                cyc++;
            end
        end
        if (!done) chk("stream_timeout", 32'd0, 32'd1);
        chk("word_count", 32'(n), 32'd44);
        if (mode == 0) chk("key_ready_cycle", 32'(cyc), 32'd85);
        chk("valid_after_stream", 32'(rk_valid), 32'd0);
    endtask

    initial begin
        logic [127:0] k1;
        logic [127:0] k2;
        int           cyc;
        bit           hit;

        build_tables();
        fips_w[0]  = 32'hd014f9a8; fips_w[1]  = 32'hc9ee2589;
        fips_w[2]  = 32'he13f0cc8; fips_w[3]  = 32'hb6630ca6;
        fips_w[4]  = 32'hac7766f3; fips_w[5]  = 32'h19fadc21;
        fips_w[6]  = 32'h28d12941; fips_w[7]  = 32'h575c006e;
        fips_w[40] = 32'h2b7e1516; fips_w[41] = 32'h28aed2a6;
        fips_w[42] = 32'habf71588; fips_w[43] = 32'h09cf4f3c;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_rk_valid", 32'(rk_valid), 32'd0);
        chk("rst_rk_word", rk_word, 32'd0);
        chk("rst_rk_round", 32'(rk_round), 32'd0);
        chk("rst_rk_idx", 32'(rk_idx), 32'd0);
        chk("rst_rk_last", 32'(rk_last), 32'd0);
        chk("rst_key_ready", 32'(key_ready), 32'd1);

        use_fips = 1;
        run_stream(FIPS_K10, 0, '0);
        run_stream(FIPS_K10, 1, '0);
        run_stream(FIPS_K10, 2, '0);
        run_stream(FIPS_K10, 3, {$urandom, $urandom, $urandom, $urandom});
        use_fips = 0;

        // Abort during the round-6 BACK phase (cycles 37..40 with ready high).
        key_in    = FIPS_K10;
        key_valid = 1'b1;
        rk_ready  = 1'b1;
        @(posedge clk);
        cyc = 1;
        hit = 0;
        while (!hit && cyc < 200) begin
            @(negedge clk);
            key_valid = 1'b0;
            if (cyc == 38) begin
                hit = 1;
                chk("abort_round", 32'(rk_round), 32'd6);
                chk("abort_in_back", 32'(rk_valid), 32'd0);
                rst_n = 1'b0;
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                chk("abort_rk_valid", 32'(rk_valid), 32'd0);
                chk("abort_key_ready", 32'(key_ready), 32'd1);
            end else begin
                @(posedge clk);
                cyc++;
            end
        end
        if (!hit) chk("abort_timeout", 32'd0, 32'd1);
        k1 = {$urandom, $urandom, $urandom, $urandom};
        run_stream(k1, 0, '0);

        // Back-to-back: each call loads at the first negedge key_ready is seen.
        k1 = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        run_stream(k1, 0, '0);
        run_stream(k2, 0, '0);

        run_stream(128'h0, 0, '0);

        for (int t = 0; t < 3; t++) begin
            k1 = {$urandom, $urandom, $urandom, $urandom};
            run_stream(k1, 1, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_inv_key_sched.md
Name: aes_inv_key_sched

Overview:
- Iterative reverse AES-128 key schedule for the decryption datapath.
- Loads the final (round-10) round key and streams round keys 10 down to 0 as 32-bit words over a valid/ready interface.
- Drives the per-word round_key operand of the inverse-cipher AddRoundKey stage.
- Regenerates keys on the fly, one word per cycle, with no 44-word key store.

Parameters:
- NR, 10, number of AES rounds; fixed for AES-128, other values unsupported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- key_in  in  128  round-10 key; [127:96] = w0 … [31:0] = w3 (FIPS-197 byte order)
- key_valid  in  1  key_in valid
- key_ready  out  1  block idle, accepts key
- rk_word  out  32  current round-key word
- rk_valid  out  1  rk_word valid
- rk_ready  in  1  consumer accepts rk_word
- rk_round  out  4  round index of rk_word (10..0)
- rk_idx  out  2  word index within round key (0..3)
- rk_last  out  1  high with the final word (round 0, idx 3)

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - FSM goes to IDLE; the 128-bit key register clears.
  - rk_valid=0, rk_word=0, rk_round=0, rk_idx=0, rk_last=0.
  - key_ready=1 from the first cycle after reset deasserts.
  - Reset mid-operation aborts the stream immediately; no further rk_valid.
- FSM states are IDLE, EMIT, BACK.
- IDLE:
  - key_ready=1 (combinational, state==IDLE only).
  - On key_valid & key_ready: K<=key_in, round<=NR, idx<=0; next EMIT.
- EMIT:
  - rk_valid=1, rk_word=K word[idx], rk_round=round, rk_idx=idx.
  - Outputs are held stable while rk_ready=0.
  - On rk_valid & rk_ready: idx increments.
  - When idx==3 is accepted and round>0: next BACK with step=0.
  - When idx==3 is accepted and round==0: next IDLE. rk_last is asserted for that word.
- BACK: four cycles, rk_valid=0, in-place update with step 0..3:
  - step0: W3 <= W3 ^ W2
  - step1: W2 <= W2 ^ W1
  - step2: W1 <= W1 ^ W0
  - step3: W0 <= W0 ^ SubWord(RotWord(W3_new)) ^ {Rcon[round],24'h0}; round decrements; idx<=0; next EMIT.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - RotWord rotates left by one byte.
- key_valid outside IDLE is ignored (key_ready=0). No queueing.
- Latency:
  - First word is valid the cycle after the key is accepted.
  - With rk_ready tied high, a full stream takes 44 EMIT + 40 BACK = 84 cycles.
  - key_ready rises on cycle 85.
- Back-to-back keys: a new key can be accepted the cycle after the rk_last handshake.
- Stalls: rk_ready=0 never alters K, round or idx.

Decomposition:
- Package aes_pkg holds:
  - typedef aes_word_t (logic [31:0])
  - typedef aes_block_t (logic [127:0])
  - constant RCON array [1:10]
  - enum ks_state_t {IDLE, EMIT, BACK}
  - functions rot_word and rcon_word
- Sub-module aes_sbox_word:
  - Purely combinational forward S-box over 4 bytes (4× byte S-box).
  - Instantiated once and reused for SubWord in step3.

Test Plan:
- FIPS-197 A.1 stream, rk_ready=1, key_in=d014f9a8_c9ee2589_e13f0cc8_b6630ca6:
  - Words 0-3 equal key_in with rk_round=10.
  - Next four words are ac7766f3,19fadc21,28d12941,575c006e with rk_round=9.
  - Final four words are 2b7e1516,28aed2a6,abf71588,09cf4f3c with rk_round=0; rk_last only on 09cf4f3c.
  - key_ready returns at cycle 85.
- Backpressure: same key, rk_ready toggling randomly or held low for 7 cycles mid-round.
  - Identical 44-word sequence; rk_word stable while stalled; no word dropped or duplicated.
- key_valid held high throughout stream with a different key_in: key_ready stays 0 and the stream is unaffected.
- Reset mid-stream: rst_n=0 for one cycle during round-6 BACK.
  - Next cycle rk_valid=0 and key_ready=1.
  - A fresh load produces a correct full stream.
- Back-to-back: second key accepted the cycle after the first stream's rk_last. Second stream correct with no idle gap beyond one cycle.
- All-zero key_in, round 10: check round-9 words against the software reference model, exercising the Rcon=36 path.
